// File: rtl/operand_read_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_read_scoreboard_pkg
// Brief    : Shared constants and types for the register-read stage and its
//            IDU/EXU neighbours.
// Revision : 1.0 - initial release
// ============================================================================
package operand_read_scoreboard_pkg;

  // Architectural x0: hardwired zero, never tracked, never bypassed.
  localparam int unsigned REG_X0 = 0;

  localparam int unsigned CTRL_WIDTH_DEF = 32;
  localparam int unsigned CNT_WIDTH_DEF  = 2;

  // Largest pending-write count a counter of the given width can hold.
  function automatic int unsigned cnt_max(input int unsigned width);
    return (1 << width) - 1;
  endfunction

  localparam int unsigned CNT_MAX = (1 << CNT_WIDTH_DEF) - 1;

  // Opaque decoded-control bundle passed IDU -> EXU untouched.
  typedef logic [CTRL_WIDTH_DEF-1:0] ctrl_t;

endpackage
`default_nettype wire

// File: rtl/operand_read_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_read_scoreboard_if
// Brief    : Bus bundle of the register-read stage: IDU issue side, register
//            file read port, writeback snoop, flush and EXU output side.
// Revision : 1.0 - initial release
// ============================================================================
interface operand_read_scoreboard_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 32
) ();

  // IDU side
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rs1;
  logic [ADDR_WIDTH-1:0] in_rs2;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_rd_wen;
  logic [CTRL_WIDTH-1:0] in_ctrl;

  // Register file read port
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;

  // Writeback snoop
  logic                  wb_valid;
  logic                  wb_wen;
  logic [ADDR_WIDTH-1:0] wb_waddr;
  logic [DATA_WIDTH-1:0] wb_wdata;

  logic                  flush;

  // EXU side
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_src1;
  logic [DATA_WIDTH-1:0] out_src2;
  logic [ADDR_WIDTH-1:0] out_rd;
  logic                  out_rd_wen;
  logic [CTRL_WIDTH-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_ctrl,
    output in_ready,
    output raddr1, raddr2,
    input  rdata1, rdata2,
    input  wb_valid, wb_wen, wb_waddr, wb_wdata,
    input  flush,
    output out_valid, out_src1, out_src2, out_rd, out_rd_wen, out_ctrl,
    input  out_ready
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_ctrl,
    input  in_ready,
    input  raddr1, raddr2,
    output rdata1, rdata2,
    output wb_valid, wb_wen, wb_waddr, wb_wdata,
    output flush,
    input  out_valid, out_src1, out_src2, out_rd, out_rd_wen, out_ctrl,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/operand_read_scoreboard_cnt.sv
`default_nettype none
// ============================================================================
// Module   : operand_read_scoreboard_cnt
// Brief    : Per-register pending-write counter array. Each counter moves by
//            +inc -clr -kill in one cycle; x0 is permanently zero.
// Revision : 1.0 - initial release
// ============================================================================
module operand_read_scoreboard_cnt #(
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                                          clock,
  input  logic                                          reset_n,
  input  logic                                          inc_en,
  input  logic [ADDR_WIDTH-1:0]                         inc_idx,
  input  logic                                          clr_en,
  input  logic [ADDR_WIDTH-1:0]                         clr_idx,
  input  logic                                          kill_en,
  input  logic [ADDR_WIDTH-1:0]                         kill_idx,
  output logic [(1<<ADDR_WIDTH)-1:0][CNT_WIDTH-1:0]     cnt
);

  localparam int NREG = 1 << ADDR_WIDTH;

  assign cnt[0] = '0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
    logic                 w_inc;
    logic                 w_clr;
    logic                 w_kill;
    logic [CNT_WIDTH:0]   w_up;
    logic [CNT_WIDTH:0]   w_down;
    logic                 w_under;
    logic [CNT_WIDTH-1:0] w_next;
    logic [CNT_WIDTH-1:0] r_cnt;

    assign w_inc   = inc_en  & (inc_idx  == ADDR_WIDTH'(gi));
    assign w_clr   = clr_en  & (clr_idx  == ADDR_WIDTH'(gi));
    assign w_kill  = kill_en & (kill_idx == ADDR_WIDTH'(gi));
    assign w_up    = (CNT_WIDTH+1)'(r_cnt) + (CNT_WIDTH+1)'(w_inc);
    assign w_down  = (CNT_WIDTH+1)'(w_clr) + (CNT_WIDTH+1)'(w_kill);
    // A decrement below zero is a protocol error; the counter saturates at 0.
    assign w_under = (w_up < w_down);
    assign w_next  = w_under ? '0 : CNT_WIDTH'(w_up - w_down);
    assign cnt[gi] = r_cnt;

    // Pending-write count of register gi.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_next;
      end
    end

    a_no_underflow : assert property (@(posedge clock) disable iff (!reset_n) !w_under);
  end

endmodule
`default_nettype wire

// File: rtl/operand_read_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : operand_read_scoreboard
// Brief    : Register-read stage between IDU and EXU. Reads two operands,
//            stalls on pending writes tracked by a counter scoreboard,
//            bypasses a same-cycle writeback, and holds the result in a
//            valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module operand_read_scoreboard
  import operand_read_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 32,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  operand_read_scoreboard_if.slave  bus
);

  localparam int                    NREG      = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0]  C_CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] C_X0      = ADDR_WIDTH'(REG_X0);

  logic [NREG-1:0][CNT_WIDTH-1:0] w_cnt;
  logic                           w_wb_fire;
  logic                           w_clr1;
  logic                           w_clr2;
  logic                           w_clr_rd;
  logic                           w_hz1;
  logic                           w_hz2;
  logic                           w_dst_stall;
  logic                           w_in_ready;
  logic                           w_fire_in;
  logic                           w_inc;
  logic                           w_kill;
  logic [DATA_WIDTH-1:0]          w_op1;
  logic [DATA_WIDTH-1:0]          w_op2;

  logic                           r_out_valid;
  logic [DATA_WIDTH-1:0]          r_src1;
  logic [DATA_WIDTH-1:0]          r_src2;
  logic [ADDR_WIDTH-1:0]          r_rd;
  logic                           r_rd_wen;
  logic [CTRL_WIDTH-1:0]          r_ctrl;

  assign bus.raddr1 = bus.in_rs1;
  assign bus.raddr2 = bus.in_rs2;

  // A writeback to x0 is architecturally a no-op and never clears anything.
  assign w_wb_fire = bus.wb_valid & bus.wb_wen & (bus.wb_waddr != C_X0);
  assign w_clr1    = w_wb_fire & (bus.wb_waddr == bus.in_rs1);
  assign w_clr2    = w_wb_fire & (bus.wb_waddr == bus.in_rs2);
  assign w_clr_rd  = w_wb_fire & (bus.wb_waddr == bus.in_rd);

  // Effective count (cnt - clr) is non-zero exactly when cnt differs from clr.
  assign w_hz1 = (bus.in_rs1 != C_X0) & (w_cnt[bus.in_rs1] != CNT_WIDTH'(w_clr1));
  assign w_hz2 = (bus.in_rs2 != C_X0) & (w_cnt[bus.in_rs2] != CNT_WIDTH'(w_clr2));

  // A writer retiring this cycle frees the slot a new writer needs.
  assign w_dst_stall = bus.in_rd_wen & (bus.in_rd != C_X0) &
                       (w_cnt[bus.in_rd] == C_CNT_MAX) & ~w_clr_rd;

  assign w_in_ready = ~w_hz1 & ~w_hz2 & ~w_dst_stall & (~r_out_valid | bus.out_ready);
  assign w_fire_in  = bus.in_valid & w_in_ready;
  assign bus.in_ready = w_in_ready;

  // The RF write lands on the same edge we sample, so a matching writeback
  // must come from wb_wdata rather than the stale read data.
  assign w_op1 = (bus.in_rs1 == C_X0) ? '0 : (w_clr1 ? bus.wb_wdata : bus.rdata1);
  assign w_op2 = (bus.in_rs2 == C_X0) ? '0 : (w_clr2 ? bus.wb_wdata : bus.rdata2);

  assign w_inc  = w_fire_in & bus.in_rd_wen & (bus.in_rd != C_X0);
  assign w_kill = bus.flush & r_out_valid & r_rd_wen & (r_rd != C_X0);

  operand_read_scoreboard_cnt #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .inc_en   (w_inc),
    .inc_idx  (bus.in_rd),
    .clr_en   (w_wb_fire),
    .clr_idx  (bus.wb_waddr),
    .kill_en  (w_kill),
    .kill_idx (r_rd),
    .cnt      (w_cnt)
  );

  // Output pipeline register: load on accept, drop on hand-off or flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_rd        <= '0;
      r_rd_wen    <= 1'b0;
      r_ctrl      <= '0;
    end else if (w_fire_in) begin
      r_out_valid <= 1'b1;
      r_src1      <= w_op1;
      r_src2      <= w_op2;
      r_rd        <= bus.in_rd;
      r_rd_wen    <= bus.in_rd_wen;
      r_ctrl      <= bus.in_ctrl;
    end else if (r_out_valid & (bus.out_ready | bus.flush)) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_src1   = r_src1;
  assign bus.out_src2   = r_src2;
  assign bus.out_rd     = r_rd;
  assign bus.out_rd_wen = r_rd_wen;
  assign bus.out_ctrl   = r_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_operand_read_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_read_scoreboard
// Brief    : Self-checking bench: vector table, hand-written corner sequences
//            and random traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_read_scoreboard;
  import operand_read_scoreboard_pkg::*;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int CW  = 32;
  localparam int CNW = 2;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  operand_read_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  operand_read_scoreboard #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CTRL_WIDTH (CW),
    .CNT_WIDTH  (CNW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Register file owned by the bench; written one step after the edge.
  logic [DW-1:0] rf [16];
  assign bus.rdata1 = (bus.raddr1 == 4'd0) ? '0 : rf[bus.raddr1];
  assign bus.rdata2 = (bus.raddr2 == 4'd0) ? '0 : rf[bus.raddr2];

  int errors = 0;
  int checks = 0;

  // Reference model: writers past the stage (oldest first) plus the held slot.
  logic [3:0] passed_q[$];
  bit         held_v;
  logic [3:0] held_rd;
  bit         held_wen;
  logic [31:0] held_s1, held_s2;
  ctrl_t      held_ctrl;

  typedef struct {
    bit          v;
    int          rs1, rs2, rd;
    bit          wen;
    bit          wb;
    int          wba;
    logic [31:0] wbd;
    bit          ordy;
    bit          e_rdy;
    bit          e_ov;
    logic [31:0] e_s1, e_s2;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pending(input logic [3:0] r);
    int n = 0;
    foreach (passed_q[k]) if (passed_q[k] == r) n++;
    if (held_v && held_wen && held_rd == r) n++;
    return n;
  endfunction

  function automatic bit wb_hits(input logic [3:0] r);
    return bus.wb_valid && bus.wb_wen && bus.wb_waddr != 4'd0 && bus.wb_waddr == r;
  endfunction

  function automatic bit src_blocked(input logic [3:0] rs);
    if (rs == 4'd0) return 1'b0;
    return (pending(rs) - int'(wb_hits(rs))) != 0;
  endfunction

  function automatic bit exp_ready();
    bit dst_full;
    dst_full = bus.in_rd_wen && bus.in_rd != 4'd0 &&
               pending(bus.in_rd) == (1 << CNW) - 1 && !wb_hits(bus.in_rd);
    return !src_blocked(bus.in_rs1) && !src_blocked(bus.in_rs2) && !dst_full &&
           (!held_v || bus.out_ready);
  endfunction

  function automatic logic [31:0] exp_op(input logic [3:0] rs);
    if (rs == 4'd0) return '0;
    if (wb_hits(rs)) return bus.wb_wdata;
    return rf[rs];
  endfunction

  task automatic model_clear();
    passed_q.delete();
    held_v = 1'b0;
  endtask

  task automatic set_in(input bit v, input int rs1, input int rs2, input int rd, input bit wen);
    bus.in_valid  = v;
    bus.in_rs1    = 4'(rs1);
    bus.in_rs2    = 4'(rs2);
    bus.in_rd     = 4'(rd);
    bus.in_rd_wen = wen;
    bus.in_ctrl   = $urandom();
  endtask

  task automatic set_wb(input bit f, input int a, input logic [31:0] d);
    bus.wb_valid = f;
    bus.wb_wen   = f;
    bus.wb_waddr = 4'(a);
    bus.wb_wdata = d;
  endtask

  task automatic set_out(input bit rdy, input bit fl);
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  // One clock: check in_ready, advance, update model, check the output register.
  task automatic step();
    bit          er, fire, wbf, ordy, fl, wen;
    logic [31:0] o1, o2, wd;
    logic [3:0]  wa, rd;
    ctrl_t       ctl;
    #1;
    er = exp_ready();
    chk("in_ready", 32'(bus.in_ready), 32'(er));
    chk("raddr1", 32'(bus.raddr1), 32'(bus.in_rs1));
    fire = bus.in_valid && er;
    o1   = exp_op(bus.in_rs1);
    o2   = exp_op(bus.in_rs2);
    wbf  = bus.wb_valid && bus.wb_wen && bus.wb_waddr != 4'd0;
    wa   = bus.wb_waddr;
    wd   = bus.wb_wdata;
    ordy = bus.out_ready;
    fl   = bus.flush;
    rd   = bus.in_rd;
    wen  = bus.in_rd_wen;
    ctl  = bus.in_ctrl;
    @(posedge clock);
    #1;
    if (wbf) begin
      rf[wa] = wd;
      for (int k = 0; k < passed_q.size(); k++) begin
        if (passed_q[k] == wa) begin
          passed_q.delete(k);
          break;
        end
      end
    end
    if (held_v) begin
      if (fl) begin
        held_v = 1'b0;
      end else if (ordy) begin
        if (held_wen && held_rd != 4'd0) passed_q.push_back(held_rd);
        held_v = 1'b0;
      end
    end
    if (fire) begin
      held_v = 1'b1; held_rd = rd; held_wen = wen;
      held_s1 = o1; held_s2 = o2; held_ctrl = ctl;
    end
    @(negedge clock);
    chk("out_valid", 32'(bus.out_valid), 32'(held_v));
    if (held_v) begin
      chk("out_src1", bus.out_src1, held_s1);
      chk("out_src2", bus.out_src2, held_s2);
      chk("out_rd", 32'(bus.out_rd), 32'(held_rd));
      chk("out_rd_wen", 32'(bus.out_rd_wen), 32'(held_wen));
      chk("out_ctrl", bus.out_ctrl, held_ctrl);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_in(1'b0, 0, 0, 0, 1'b0);
    set_wb(1'b0, 0, 32'h0);
    set_out(1'b0, 1'b0);
    model_clear();
    repeat (2) @(negedge clock);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_src1", bus.out_src1, 32'h0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + 32'(i);
    rf[0] = 32'h0;
    rf[3] = 32'h11;

    //          v  rs1 rs2 rd wen wb wba wbd         ordy rdy ov  s1          s2
    vt[0] = '{1'b1, 3, 0, 0, 1'b0, 1'b0, 0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h11,    32'h0};
    vt[1] = '{1'b1, 1, 2, 5, 1'b1, 1'b0, 0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h1001,  32'h1002};
    vt[2] = '{1'b1, 5, 0, 0, 1'b0, 1'b0, 0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0,     32'h0};
    vt[3] = '{1'b1, 5, 0, 0, 1'b0, 1'b0, 0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0,     32'h0};
    vt[4] = '{1'b1, 5, 0, 0, 1'b0, 1'b1, 5, 32'hABCD,  1'b1, 1'b1, 1'b1, 32'hABCD,  32'h0};
    vt[5] = '{1'b1, 0, 0, 0, 1'b1, 1'b1, 0, 32'hFFFF,  1'b1, 1'b1, 1'b1, 32'h0,     32'h0};
    vt[6] = '{1'b1, 0, 5, 0, 1'b0, 1'b0, 0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h0,     32'hABCD};
    vt[7] = '{1'b1, 1, 0, 6, 1'b1, 1'b0, 0, 32'h0,     1'b0, 1'b0, 1'b1, 32'h0,     32'hABCD};
    vt[8] = '{1'b1, 1, 0, 6, 1'b1, 1'b0, 0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h1001,  32'h0};

    do_reset();

    // Vector table: basic issue, RAW stall with bypass, x0 traffic, back-pressure.
    for (int i = 0; i < 9; i++) begin
      set_in(vt[i].v, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].wen);
      set_wb(vt[i].wb, vt[i].wba, vt[i].wbd);
      set_out(vt[i].ordy, 1'b0);
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'(vt[i].e_rdy));
      step();
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].e_ov));
      if (vt[i].e_ov) begin
        chk($sformatf("vec%0d_src1", i), bus.out_src1, vt[i].e_s1);
        chk($sformatf("vec%0d_src2", i), bus.out_src2, vt[i].e_s2);
      end
    end

    // Three writers to x7 saturate the counter; issue+wb keeps it full.
    do_reset();
    set_out(1'b1, 1'b0);
    set_wb(1'b0, 0, 32'h0);
    repeat (3) begin
      set_in(1'b1, 0, 0, 7, 1'b1);
      step();
    end
    chk("x7_full_stall", 32'(bus.in_ready), 32'h0);
    step();
    set_wb(1'b1, 7, 32'h7777);
    #1;
    chk("x7_issue_with_wb", 32'(bus.in_ready), 32'h1);
    step();
    set_wb(1'b0, 0, 32'h0);
    set_out(1'b0, 1'b0);
    #1;
    chk("x7_still_full", 32'(bus.in_ready), 32'h0);
    step();

    // Asynchronous reset while stalled with a held instruction.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
    set_in(1'b0, 0, 0, 0, 1'b0);
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
    set_in(1'b1, 7, 0, 7, 1'b1);
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'h1);
    step();
    chk("post_rst_src1", bus.out_src1, 32'h7777);

    // Flush drops the held writer and releases its pending count.
    do_reset();
    set_wb(1'b0, 0, 32'h0);
    set_out(1'b0, 1'b0);
    set_in(1'b1, 0, 0, 9, 1'b1);
    step();
    set_in(1'b0, 0, 0, 0, 1'b0);
    set_out(1'b0, 1'b1);
    step();
    chk("flush_drop", 32'(bus.out_valid), 32'h0);
    set_out(1'b0, 1'b0);
    set_in(1'b1, 9, 9, 0, 1'b0);
    #1;
    chk("after_flush_ready", 32'(bus.in_ready), 32'h1);
    step();
    chk("after_flush_src1", bus.out_src1, 32'h1009);
    set_out(1'b1, 1'b1);
    set_in(1'b1, 1, 0, 10, 1'b1);
    #1;
    chk("flush_fire_ready", 32'(bus.in_ready), 32'h1);
    step();
    chk("flush_fire_valid", 32'(bus.out_valid), 32'h1);
    chk("flush_fire_src1", bus.out_src1, 32'h1001);
    set_out(1'b0, 1'b0);
    set_in(1'b1, 10, 0, 0, 1'b0);
    #1;
    chk("rs10_hazard", 32'(bus.in_ready), 32'h0);
    step();
    set_out(1'b0, 1'b1);
    set_in(1'b0, 0, 0, 0, 1'b0);
    step();
    set_out(1'b0, 1'b0);
    set_in(1'b1, 10, 0, 0, 1'b0);
    #1;
    chk("rs10_after_kill", 32'(bus.in_ready), 32'h1);
    step();

    // Random traffic against the model; writebacks retire in program order.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      set_in(($urandom % 4) != 0, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 5)), 1'($urandom % 2));
      if (passed_q.size() > 0 && ($urandom % 2) == 1) begin
        set_wb(1'b1, int'(passed_q[0]), $urandom());
      end else begin
        bus.wb_valid = 1'($urandom % 2);
        bus.wb_wen   = 1'($urandom % 2);
        bus.wb_waddr = bus.wb_wen ? 4'd0 : 4'($urandom_range(0, 15));
        bus.wb_wdata = $urandom();
      end
      set_out(($urandom % 4) != 0, ($urandom % 8) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
